// File: rtl/ssemi_cic_ctrl_pkg.sv
// ssemi_cic_ctrl_pkg: shared types, defaults and decimation factor validation for the CIC controller
package ssemi_cic_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } cic_ctrl_state_e;
  typedef logic [15:0] dec_factor_t;
  typedef logic [7:0] overrun_cnt_t;
  localparam int MIN_DEC_DEF = 32;
  localparam int MAX_DEC_DEF = 512;
  function automatic logic dec_legal(input dec_factor_t f, input int mn, input int mx);
    return (int'(f) >= mn) && (int'(f) <= mx) && (f != '0) && ((f & (f - 16'd1)) == '0);
  endfunction
endpackage

// File: rtl/ssemi_cic_out_reg.sv
// ssemi_cic_out_reg: single-entry valid/ready output register with overwrite and overrun pulse
module ssemi_cic_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_overrun
);
  assign o_overrun = i_load && o_valid && !i_ready;
  // hold one sample; a new load overwrites, a handshake or flush empties it
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_data  <= i_data;
      o_valid <= 1'b1;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/ssemi_cic_ctrl.sv
// ssemi_cic_ctrl: CIC sequencing controller (flush, settle-discard, run, fault); SSEMI_CIC_CTRL_AUTO_RECOVER_EN enables timed fault recovery
module ssemi_cic_ctrl
  import ssemi_cic_ctrl_pkg::*;
#(
  parameter int CIC_STAGES         = 5,
  parameter int DIFFERENTIAL_DELAY = 1,
  parameter int DATA_WIDTH         = 32,
  parameter int MIN_DEC            = MIN_DEC_DEF,
  parameter int MAX_DEC            = MAX_DEC_DEF,
  parameter int FLUSH_CYCLES       = 4,
  parameter int RECOVER_CYCLES     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_clear_fault,
  input  logic [15:0]           i_dec_factor,
  input  logic                  i_adc_valid,
  output logic                  o_cic_enable,
  output logic                  o_cic_valid,
  output logic [15:0]           o_cic_dec_factor,
  input  logic [DATA_WIDTH-1:0] i_cic_data,
  input  logic                  i_cic_valid,
  input  logic                  i_cic_overflow,
  input  logic                  i_cic_underflow,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [2:0]            o_state,
  output logic                  o_cfg_error,
  output logic                  o_fault,
  output logic [7:0]            o_overrun_cnt,
  output logic                  o_busy
);
  localparam int SETTLE_N = CIC_STAGES * DIFFERENTIAL_DELAY;
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam int SCW = $clog2(SETTLE_N + 1);
  cic_ctrl_state_e state;
  logic [FCW-1:0] fcnt;
  logic [SCW-1:0] scnt;
  dec_factor_t dec;
  overrun_cnt_t ovr;
  logic cfg_err;
  logic flt, start_ok, active, stay_run, load, overrun;
  assign flt      = i_cic_overflow || i_cic_underflow;
  assign start_ok = i_start && dec_legal(i_dec_factor, MIN_DEC, MAX_DEC);
  assign active   = (state == ST_SETTLE) || (state == ST_RUN);
  assign stay_run = (state == ST_RUN) && !i_stop && !flt && !start_ok;
  assign load     = stay_run && i_cic_valid;
  assign o_cic_enable     = active;
  assign o_cic_valid      = active && i_adc_valid;
  assign o_cic_dec_factor = dec;
  assign o_state          = state;
  assign o_cfg_error      = cfg_err;
  assign o_fault          = state == ST_FAULT;
  assign o_overrun_cnt    = ovr;
  assign o_busy           = state != ST_IDLE;
`ifdef SSEMI_CIC_CTRL_AUTO_RECOVER_EN
  localparam int RCW = $clog2(RECOVER_CYCLES + 1);
  logic [RCW-1:0] rcnt;
`else
  logic unused_rec;
  assign unused_rec = ^RECOVER_CYCLES;
`endif
  ssemi_cic_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_flush  (!stay_run),
    .i_load   (load),
    .i_data   (i_cic_data),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_overrun(overrun)
  );
  // sequencing FSM with flush/settle/recover counters, config latch and overrun counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      fcnt    <= '0;
      scnt    <= '0;
      dec     <= dec_factor_t'(MIN_DEC);
      ovr     <= '0;
      cfg_err <= 1'b0;
`ifdef SSEMI_CIC_CTRL_AUTO_RECOVER_EN
      rcnt    <= '0;
`endif
    end else begin
      if (overrun && ovr != '1) ovr <= ovr + 1'b1;
`ifdef SSEMI_CIC_CTRL_AUTO_RECOVER_EN
      rcnt <= '0;
`endif
      if (state == ST_FAULT) begin
        if (i_stop) state <= ST_IDLE;
        else if (i_clear_fault) begin
          state <= ST_FLUSH;
          fcnt  <= '0;
        end
`ifdef SSEMI_CIC_CTRL_AUTO_RECOVER_EN
        else if (rcnt == RCW'(RECOVER_CYCLES - 1)) begin
          state <= ST_FLUSH;
          fcnt  <= '0;
        end else rcnt <= rcnt + 1'b1;
`endif
      end else if (state != ST_IDLE && i_stop) begin
        state <= ST_IDLE;
      end else if (active && flt) begin
        state <= ST_FAULT;
      end else if (start_ok) begin
        state   <= ST_FLUSH;
        fcnt    <= '0;
        dec     <= i_dec_factor;
        cfg_err <= 1'b0;
        ovr     <= '0;
      end else begin
        if (i_start) cfg_err <= 1'b1;
        if (state == ST_FLUSH) begin
          if (fcnt == FCW'(FLUSH_CYCLES - 1)) begin
            state <= ST_SETTLE;
            scnt  <= '0;
          end else fcnt <= fcnt + 1'b1;
        end
        if (state == ST_SETTLE && i_cic_valid) begin
          if (scnt == SCW'(SETTLE_N - 1)) state <= ST_RUN;
          else scnt <= scnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ssemi_cic_ctrl.sv
// tb_ssemi_cic_ctrl: randomized self-checking bench for ssemi_cic_ctrl against a behavioural model
module tb_ssemi_cic_ctrl;
  localparam int DW = 32;
  localparam int FLUSH = 4;
  localparam int SETTLE_N = 5;
  localparam int REC = 16;
  logic i_clk = 0, i_rst_n = 0, i_start = 0, i_stop = 0, i_clear_fault = 0;
  logic [15:0] i_dec_factor = 0;
  logic i_adc_valid = 0, i_cic_valid = 0, i_cic_overflow = 0, i_cic_underflow = 0, i_ready = 0;
  logic [DW-1:0] i_cic_data = 0;
  logic o_cic_enable, o_cic_valid, o_valid, o_cfg_error, o_fault, o_busy;
  logic [15:0] o_cic_dec_factor;
  logic [DW-1:0] o_data;
  logic [2:0] o_state;
  logic [7:0] o_overrun_cnt;
  int checks = 0, failures = 0;

  ssemi_cic_ctrl #(.CIC_STAGES(5), .DIFFERENTIAL_DELAY(1), .DATA_WIDTH(DW), .MIN_DEC(32),
                   .MAX_DEC(512), .FLUSH_CYCLES(FLUSH), .RECOVER_CYCLES(REC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop),
    .i_clear_fault(i_clear_fault), .i_dec_factor(i_dec_factor), .i_adc_valid(i_adc_valid),
    .o_cic_enable(o_cic_enable), .o_cic_valid(o_cic_valid), .o_cic_dec_factor(o_cic_dec_factor),
    .i_cic_data(i_cic_data), .i_cic_valid(i_cic_valid), .i_cic_overflow(i_cic_overflow),
    .i_cic_underflow(i_cic_underflow), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_state(o_state), .o_cfg_error(o_cfg_error), .o_fault(o_fault),
    .o_overrun_cnt(o_overrun_cnt), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] f);
    i_start = 1; i_dec_factor = f;
    step();
    i_start = 0;
  endtask

  task automatic do_stop();
    i_stop = 1;
    step();
    i_stop = 0;
  endtask

  task automatic bring_up(input logic [15:0] f);
    do_start(f);
    repeat (FLUSH) step();
    repeat (SETTLE_N) begin
      i_cic_valid = 1; i_cic_data = $urandom;
      step();
    end
    i_cic_valid = 0;
  endtask

  task automatic test_reset();
    i_rst_n = 0; i_adc_valid = 1;
    step(); step();
    checks++;
    if ({o_state, o_cic_enable, o_cic_valid, o_valid, o_cfg_error, o_fault, o_busy, o_overrun_cnt, o_data, o_cic_dec_factor}
        !== {3'd0, 6'b0, 8'd0, 32'd0, 16'd32}) begin
      failures++;
      $display("FAIL reset_state got st=%0d en=%b cv=%b v=%b err=%b flt=%b busy=%b ovr=%0d data=%h dec=%0d exp all zero dec=32",
               o_state, o_cic_enable, o_cic_valid, o_valid, o_cfg_error, o_fault, o_busy, o_overrun_cnt, o_data, o_cic_dec_factor);
    end
    i_rst_n = 1; i_adc_valid = 0;
    step();
  endtask

  task automatic test_startup();
    logic [DW-1:0] d;
    i_ready = 0;
    do_start(64);
    for (int i = 0; i < FLUSH; i++) begin
      i_adc_valid = 1; #1;
      checks++;
      if ({o_state, o_cic_enable, o_cic_valid} !== {3'd1, 2'b00}) begin
        failures++;
        $display("FAIL flush_cycle%0d got st=%0d en=%b cv=%b exp st=1 en=0 cv=0", i, o_state, o_cic_enable, o_cic_valid);
      end
      i_adc_valid = 0;
      step();
    end
    i_adc_valid = 1; #1;
    checks++;
    if ({o_state, o_cic_enable, o_cic_valid} !== {3'd2, 2'b11}) begin
      failures++;
      $display("FAIL settle_entry got st=%0d en=%b cv=%b exp st=2 en=1 cv=1", o_state, o_cic_enable, o_cic_valid);
    end
    i_adc_valid = 0;
    for (int i = 0; i < SETTLE_N; i++) begin
      checks++;
      if (o_state !== 3'd2) begin
        failures++;
        $display("FAIL settle_hold%0d got st=%0d exp 2", i, o_state);
      end
      i_cic_valid = 1; i_cic_data = $urandom;
      step();
      checks++;
      if (o_valid !== 1'b0) begin
        failures++;
        $display("FAIL settle_discard%0d got o_valid=%b exp 0", i, o_valid);
      end
    end
    i_cic_valid = 0;
    checks++;
    if (o_state !== 3'd3) begin
      failures++;
      $display("FAIL run_entry got st=%0d exp 3", o_state);
    end
    d = $urandom;
    i_cic_valid = 1; i_cic_data = d;
    step();
    i_cic_valid = 0;
    checks++;
    if (o_valid !== 1'b1 || o_data !== d) begin
      failures++;
      $display("FAIL first_sample got v=%b data=%h exp v=1 data=%h", o_valid, o_data, d);
    end
    i_ready = 1;
    step();
    i_ready = 0;
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_xfer got o_valid=%b exp 0", o_valid);
    end
  endtask

  task automatic test_overrun();
    logic [DW-1:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    i_ready = 0;
    for (int i = 0; i < 3; i++) begin
      i_cic_valid = 1; i_cic_data = vals[i];
      step();
    end
    i_cic_valid = 0;
    checks++;
    if (o_overrun_cnt !== 8'd2 || o_data !== 32'h33 || o_valid !== 1'b1) begin
      failures++;
      $display("FAIL overrun got ovr=%0d data=%h v=%b exp ovr=2 data=33 v=1", o_overrun_cnt, o_data, o_valid);
    end
    i_ready = 1;
    step();
    i_ready = 0;
    checks++;
    if (o_valid !== 1'b0 || o_overrun_cnt !== 8'd2) begin
      failures++;
      $display("FAIL overrun_drain got v=%b ovr=%0d exp v=0 ovr=2", o_valid, o_overrun_cnt);
    end
  endtask

  task automatic test_cfg();
    logic [15:0] tbl [7];
    logic [15:0] exp_dec;
    logic [15:0] f;
    logic legal;
    do_stop();
    checks++;
    if (o_state !== 3'd0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_idle got st=%0d busy=%b exp st=0 busy=0", o_state, o_busy);
    end
    do_start(48);
    checks++;
    if (o_cfg_error !== 1'b1 || o_state !== 3'd0 || o_cic_dec_factor !== 16'd64) begin
      failures++;
      $display("FAIL cfg_48 got err=%b st=%0d dec=%0d exp err=1 st=0 dec=64", o_cfg_error, o_state, o_cic_dec_factor);
    end
    do_start(1024);
    checks++;
    if (o_cfg_error !== 1'b1 || o_state !== 3'd0 || o_cic_dec_factor !== 16'd64) begin
      failures++;
      $display("FAIL cfg_1024 got err=%b st=%0d dec=%0d exp err=1 st=0 dec=64", o_cfg_error, o_state, o_cic_dec_factor);
    end
    do_start(128);
    checks++;
    if (o_cfg_error !== 1'b0 || o_state !== 3'd1 || o_cic_dec_factor !== 16'd128) begin
      failures++;
      $display("FAIL cfg_128 got err=%b st=%0d dec=%0d exp err=0 st=1 dec=128", o_cfg_error, o_state, o_cic_dec_factor);
    end
    do_stop();
    exp_dec = 128;
    tbl[0] = 32; tbl[1] = 512; tbl[2] = 16; tbl[3] = 1024; tbl[4] = 0; tbl[5] = 33; tbl[6] = 256;
    for (int i = 0; i < 40; i++) begin
      f = (i < 7) ? tbl[i] : (($urandom % 3 == 0) ? 16'(1 << ($urandom % 14)) : 16'($urandom % 1100));
      legal = (f >= 32) && (f <= 512) && ($countones(f) == 1);
      if (legal) exp_dec = f;
      do_start(f);
      checks++;
      if (o_state !== (legal ? 3'd1 : 3'd0) || o_cfg_error !== !legal || o_cic_dec_factor !== exp_dec) begin
        failures++;
        $display("FAIL cfg_rand f=%0d got st=%0d err=%b dec=%0d exp st=%0d err=%b dec=%0d",
                 f, o_state, o_cfg_error, o_cic_dec_factor, legal ? 1 : 0, !legal, exp_dec);
      end
      if (legal) do_stop();
    end
  endtask

  task automatic test_run_random();
    logic exp_v;
    logic [DW-1:0] exp_d, d;
    int exp_ovr;
    logic v, r, a;
    bring_up(512);
    exp_v = 0; exp_d = '0; exp_ovr = 0;
    for (int i = 0; i < 1000; i++) begin
      v = 1'($urandom % 2); r = ($urandom % 4 == 0); a = 1'($urandom % 2); d = $urandom;
      i_cic_valid = v; i_ready = r; i_adc_valid = a; i_cic_data = d;
      #1;
      checks++;
      if (o_cic_valid !== a) begin
        failures++;
        $display("FAIL run_gate cyc=%0d got cv=%b exp %b", i, o_cic_valid, a);
      end
      step();
      if (v) begin
        if (exp_v && !r) exp_ovr = (exp_ovr == 255) ? 255 : exp_ovr + 1;
        exp_d = d; exp_v = 1;
      end else if (exp_v && r) exp_v = 0;
      checks++;
      if (o_valid !== exp_v || (exp_v && o_data !== exp_d) || o_overrun_cnt !== 8'(exp_ovr)) begin
        failures++;
        $display("FAIL run_model cyc=%0d got v=%b data=%h ovr=%0d exp v=%b data=%h ovr=%0d",
                 i, o_valid, o_data, o_overrun_cnt, exp_v, exp_d, exp_ovr);
      end
    end
    i_cic_valid = 0; i_ready = 0; i_adc_valid = 0;
    do_start(128);
    checks++;
    if (o_state !== 3'd1 || o_overrun_cnt !== 8'd0 || o_valid !== 1'b0 || o_cic_dec_factor !== 16'd128) begin
      failures++;
      $display("FAIL run_restart got st=%0d ovr=%0d v=%b dec=%0d exp st=1 ovr=0 v=0 dec=128",
               o_state, o_overrun_cnt, o_valid, o_cic_dec_factor);
    end
    do_stop();
  endtask

  task automatic test_run_bad_cfg();
    bring_up(64);
    do_start(100);
    checks++;
    if (o_state !== 3'd3 || o_cfg_error !== 1'b1 || o_cic_dec_factor !== 16'd64) begin
      failures++;
      $display("FAIL run_bad_cfg got st=%0d err=%b dec=%0d exp st=3 err=1 dec=64", o_state, o_cfg_error, o_cic_dec_factor);
    end
  endtask

  task automatic test_fault();
    i_cic_overflow = 1;
    step();
    i_cic_overflow = 0;
    i_adc_valid = 1; #1;
    checks++;
    if ({o_state, o_fault, o_cic_enable, o_cic_valid, o_valid} !== {3'd4, 4'b1000}) begin
      failures++;
      $display("FAIL fault_entry got st=%0d flt=%b en=%b cv=%b v=%b exp st=4 flt=1 rest 0",
               o_state, o_fault, o_cic_enable, o_cic_valid, o_valid);
    end
    i_adc_valid = 0;
`ifdef SSEMI_CIC_CTRL_AUTO_RECOVER_EN
    for (int i = 1; i < REC; i++) begin
      step();
      checks++;
      if (o_state !== 3'd4) begin
        failures++;
        $display("FAIL fault_hold cyc=%0d got st=%0d exp 4", i, o_state);
      end
    end
    step();
`else
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (o_state !== 3'd4) begin
        failures++;
        $display("FAIL fault_hold cyc=%0d got st=%0d exp 4", i, o_state);
      end
    end
    i_clear_fault = 1;
    step();
    i_clear_fault = 0;
`endif
    checks++;
    if (o_state !== 3'd1 || o_fault !== 1'b0 || o_cic_dec_factor !== 16'd64) begin
      failures++;
      $display("FAIL fault_exit got st=%0d flt=%b dec=%0d exp st=1 flt=0 dec=64", o_state, o_fault, o_cic_dec_factor);
    end
    repeat (FLUSH) step();
    i_cic_underflow = 1;
    step();
    i_cic_underflow = 0;
    checks++;
    if (o_state !== 3'd4) begin
      failures++;
      $display("FAIL underflow_settle got st=%0d exp 4", o_state);
    end
    i_stop = 1; i_clear_fault = 1;
    step();
    i_stop = 0; i_clear_fault = 0;
    checks++;
    if (o_state !== 3'd0 || o_fault !== 1'b0) begin
      failures++;
      $display("FAIL fault_stop got st=%0d flt=%b exp st=0 flt=0", o_state, o_fault);
    end
  endtask

  task automatic test_stop_start();
    bring_up(64);
    i_start = 1; i_dec_factor = 256; i_stop = 1;
    step();
    i_start = 0; i_stop = 0;
    checks++;
    if (o_state !== 3'd0 || o_cic_dec_factor !== 16'd64 || o_cic_enable !== 1'b0 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL stop_priority got st=%0d dec=%0d en=%b v=%b exp st=0 dec=64 en=0 v=0",
               o_state, o_cic_dec_factor, o_cic_enable, o_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_start(256);
    repeat (FLUSH) step();
    checks++;
    if (o_state !== 3'd2) begin
      failures++;
      $display("FAIL pre_reset got st=%0d exp 2", o_state);
    end
    i_rst_n = 0; i_adc_valid = 1;
    step();
    checks++;
    if ({o_state, o_cic_enable, o_cic_valid, o_valid, o_cfg_error, o_fault, o_busy, o_overrun_cnt, o_cic_dec_factor}
        !== {3'd0, 6'b0, 8'd0, 16'd32}) begin
      failures++;
      $display("FAIL reset_mid got st=%0d en=%b cv=%b v=%b err=%b flt=%b busy=%b ovr=%0d dec=%0d exp all zero dec=32",
               o_state, o_cic_enable, o_cic_valid, o_valid, o_cfg_error, o_fault, o_busy, o_overrun_cnt, o_cic_dec_factor);
    end
    i_rst_n = 1; i_adc_valid = 0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_overrun();
    test_cfg();
    test_run_random();
    test_run_bad_cfg();
    test_fault();
    test_stop_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
